// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, 0.1 s prescaler, M:SS.t BCD count chain
// and a registered four-digit multiplexed display scan.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START_STOP,
  input  logic        CLEAR,
  output logic        RUNNING,
  output logic [15:0] COUNT_BCD,
  output logic [3:0]  DIGIT_DATA,
  output logic [3:0]  DIGIT_SEL
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE = SW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic          running_q;
  logic [3:0]    data_q, data_d;
  logic [3:0]    sel_q;
  logic          tick;

  assign tick = (state_q == S_RUN) && (pre_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (START_STOP) state_d = S_RUN;
      S_RUN:   if (START_STOP) state_d = S_PAUSE;
      // CLEAR takes priority over START_STOP while paused
      S_PAUSE: if (CLEAR) state_d = S_IDLE;
               else if (START_STOP) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q;
    unique case (state_q)
      S_IDLE:  pre_d = '0;
      S_RUN:   pre_d = tick ? '0 : pre_q + PRE_ONE;
      S_PAUSE: if (CLEAR) pre_d = '0;
      default: pre_d = '0;
    endcase
  end

  // Ripple-carry BCD chain: tenths 0-9, sec units 0-9, sec tens 0-5, minutes 0-9
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_PAUSE && CLEAR) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q[3:0] != 4'd9) begin
        cnt_d[3:0] = cnt_q[3:0] + 4'd1;
      end else begin
        cnt_d[3:0] = 4'd0;
        if (cnt_q[7:4] != 4'd9) begin
          cnt_d[7:4] = cnt_q[7:4] + 4'd1;
        end else begin
          cnt_d[7:4] = 4'd0;
          if (cnt_q[11:8] != 4'd5) begin
            cnt_d[11:8] = cnt_q[11:8] + 4'd1;
          end else begin
            cnt_d[11:8] = 4'd0;
            cnt_d[15:12] = (cnt_q[15:12] != 4'd9) ? cnt_q[15:12] + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SCAN_ONE;
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    unique case (idx_d)
      2'd0:    data_d = cnt_q[3:0];
      2'd1:    data_d = cnt_q[7:4];
      2'd2:    data_d = cnt_q[11:8];
      default: data_d = cnt_q[15:12];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      scan_q    <= '0;
      idx_q     <= 2'd0;
      sel_q     <= 4'b0001;
      data_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == S_RUN);
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      sel_q     <= 4'b0001 << idx_d;
      data_q    <= data_d;
    end
  end

  assign RUNNING    = running_q;
  assign COUNT_BCD  = cnt_q;
  assign DIGIT_DATA = data_q;
  assign DIGIT_SEL  = sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random pulses, all compared
// every cycle against an elapsed-tenths reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        running;
  logic [15:0] count_bcd;
  logic [3:0]  digit_data;
  logic [3:0]  digit_sel;

  int n_chk = 0;
  int n_err = 0;

  // reference model: mode 0 idle, 1 run, 2 pause; m_tot = elapsed tenths
  int         m_mode = 0;
  int         m_pre  = 0;
  int         m_tot  = 0;
  int         m_scan = 0;
  int         m_idx  = 0;
  logic [3:0] m_data = 4'h0;

  stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .CLK(clk), .RST(rst), .START_STOP(start), .CLEAR(clear),
    .RUNNING(running), .COUNT_BCD(count_bcd),
    .DIGIT_DATA(digit_data), .DIGIT_SEL(digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int t);
    logic [15:0] r;
    r[3:0]   = 4'(t % 10);
    r[7:4]   = 4'((t / 10) % 10);
    r[11:8]  = 4'((t / 100) % 6);
    r[15:12] = 4'(t / 600);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic ss, input logic cl, input logic rs);
    logic [15:0] old;
    bit tk;
    if (rs) begin
      m_mode = 0; m_pre = 0; m_tot = 0; m_scan = 0; m_idx = 0; m_data = 4'h0;
      return;
    end
    old = to_bcd(m_tot);
    tk = (m_mode == 1) && (m_pre == TD - 1);
    if (m_mode == 1) m_pre = tk ? 0 : m_pre + 1;
    else if (m_mode == 0) m_pre = 0;
    if (tk) m_tot = (m_tot + 1) % 6000;
    case (m_mode)
      0: if (ss) m_mode = 1;
      1: if (ss) m_mode = 2;
      default: if (cl) begin m_mode = 0; m_tot = 0; m_pre = 0; end
               else if (ss) m_mode = 1;
    endcase
    m_scan++;
    if (m_scan == SD) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
    m_data = old[m_idx*4 +: 4];
  endtask

  task automatic step(input logic ss, input logic cl, input logic rs);
    @(negedge clk);
    start = ss; clear = cl; rst = rs;
    @(posedge clk);
    model_edge(ss, cl, rs);
    #1;
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("count", 32'(count_bcd), 32'(to_bcd(m_tot)));
    chk("sel", 32'(digit_sel), 32'(4'b0001 << m_idx));
    chk("data", 32'(digit_data), 32'(m_data));
  endtask

  task automatic run_to(input int t);
    int b = 30000;
    while (m_tot != t && b > 0) begin
      step(1'b0, 1'b0, 1'b0);
      b--;
    end
  endtask

  initial begin
    logic [15:0] exp_cnt;
    logic [3:0]  prev_sel;
    int b;

    // reset
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_count", 32'(count_bcd), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_sel", 32'(digit_sel), 32'h1);
    chk("rst_data", 32'(digit_data), 32'h0);

    // first start right after reset, first ticks
    step(1'b1, 1'b0, 1'b0);
    chk("start_running", 32'(running), 32'h1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("pre_tick", 32'(count_bcd), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("tick_e4", 32'(count_bcd), 32'h0001);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("tick_e8", 32'(count_bcd), 32'h0002);

    // long runs through carries and the 9:59.9 wrap
    run_to(100);
    chk("run_100", 32'(count_bcd), 32'h0100);
    run_to(600);
    chk("run_600", 32'(count_bcd), 32'h1000);
    run_to(5999);
    chk("run_9599", 32'(count_bcd), 32'h9599);
    run_to(0);
    chk("wrap_count", 32'(count_bcd), 32'h0000);
    chk("wrap_running", 32'(running), 32'h1);

    // pause, hold, clear, clear-while-run ignored
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run_to(3);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("pause_hold", 32'(count_bcd), 32'h0003);
    chk("pause_running", 32'(running), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("clear_count", 32'(count_bcd), 32'h0000);
    chk("clear_running", 32'(running), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("clear_idle", 32'(running), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    run_to(2);
    step(1'b0, 1'b1, 1'b0);
    chk("clear_in_run_cnt", 32'(count_bcd), 32'h0002);
    chk("clear_in_run_state", 32'(running), 32'h1);

    // both pulses together: in RUN pauses, in PAUSE clears
    step(1'b1, 1'b1, 1'b0);
    exp_cnt = count_bcd;
    chk("both_run_running", 32'(running), 32'h0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("both_run_held", 32'(count_bcd), 32'(exp_cnt));
    step(1'b1, 1'b1, 1'b0);
    chk("both_pause_cnt", 32'(count_bcd), 32'h0);
    chk("both_pause_running", 32'(running), 32'h0);

    // pause on a tick edge: that increment still lands
    step(1'b1, 1'b0, 1'b0);
    run_to(7);
    while (m_pre != TD - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pause_on_tick", 32'(count_bcd), 32'h0008);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("pause_on_tick_hold", 32'(count_bcd), 32'h0008);

    // display scan of 1:23.4
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run_to(834);
    step(1'b1, 1'b0, 1'b0);
    chk("scan_count", 32'(count_bcd), 32'h1234);
    prev_sel = digit_sel;
    b = 20;
    step(1'b0, 1'b0, 1'b0);
    while (!(digit_sel == 4'b0001 && prev_sel == 4'b1000) && b > 0) begin
      prev_sel = digit_sel;
      step(1'b0, 1'b0, 1'b0);
      b--;
    end
    for (int k = 0; k < 4; k++) begin
      chk("scan_sel", 32'(digit_sel), 32'(4'b0001 << k));
      chk("scan_data", 32'(digit_data), 32'(4 - k));
      step(1'b0, 1'b0, 1'b0);
      chk("scan_hold", 32'(digit_sel), 32'(4'b0001 << k));
      step(1'b0, 1'b0, 1'b0);
    end

    // reset mid-run overrides both pulses
    step(1'b1, 1'b0, 1'b0);
    repeat (13) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_count", 32'(count_bcd), 32'h0);
    chk("midrst_running", 32'(running), 32'h0);
    chk("midrst_sel", 32'(digit_sel), 32'h1);
    chk("midrst_data", 32'(digit_data), 32'h0);

    // random pulse traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clock cycles per 0.1 s count tick; legal range 2..2^24.
REQ-002 Parameter SCAN_DIV, default 10000, clock cycles each display digit is held; legal range 2..2^16.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 START_STOP  input  1  single-cycle pulse (debounced upstream); toggles run/pause.
REQ-006 CLEAR  input  1  single-cycle pulse; zeroes the count when paused.
REQ-007 RUNNING  output  1  high while in RUN state.
REQ-008 COUNT_BCD  output  16  {min[3:0], sec_tens[3:0], sec_units[3:0], tenths[3:0]}, registered.
REQ-009 DIGIT_DATA  output  4  BCD value of the currently scanned digit; drives the 7-segment decoder DATA_IN.
REQ-010 DIGIT_SEL  output  4  one-hot, active-high digit enable; bit0 = tenths … bit3 = minutes.

Function
REQ-011 FSM states IDLE, RUN, PAUSE; encoding is free.
REQ-012 IDLE + START_STOP -> RUN; RUN + START_STOP -> PAUSE; PAUSE + START_STOP -> RUN (count resumes).
REQ-013 PAUSE + CLEAR -> IDLE, COUNT_BCD = 0 on the same edge.
REQ-014 CLEAR in RUN or IDLE: ignored, no state or count change.
REQ-015 START_STOP and CLEAR in the same cycle: PAUSE -> CLEAR wins (go IDLE, zero count); RUN -> START_STOP acts (go PAUSE); IDLE -> go RUN.
REQ-016 RUNNING updates on the edge that samples START_STOP (1-cycle latency from the pulse).
REQ-017 Prescaler counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSE; cleared to 0 in IDLE and on IDLE->RUN.
REQ-018 Tick asserted when prescaler == TICK_DIV-1 in RUN; prescaler wraps to 0 and count increments on that edge.
REQ-019 After IDLE->RUN at edge n, first increment visible after edge n+TICK_DIV.
REQ-020 Count chain: tenths 0..9; carry -> sec_units 0..9; carry -> sec_tens 0..5; carry -> min 0..9.
REQ-021 9:59.9 + tick -> 0:00.0, RUN continues; no overflow flag.
REQ-022 Each BCD digit never holds a value outside its range above; no binary-to-BCD conversion allowed.
REQ-023 Scan counter runs in all states, counting 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-024 DIGIT_SEL = 1 << index; DIGIT_DATA = COUNT_BCD digit[index]; both registered and change on the same edge.
REQ-025 DIGIT_DATA reflects the count value one cycle after a count update when that digit is selected.
REQ-026 RUN->PAUSE on a tick edge: the increment on that edge takes effect, then the count holds.

Reset
REQ-027 RST high at a rising edge: state IDLE, prescaler 0, COUNT_BCD 16'h0000, RUNNING 0.
REQ-028 Reset values: scan counter 0, index 0, DIGIT_SEL 4'b0001, DIGIT_DATA 4'h0.
REQ-029 RST overrides START_STOP and CLEAR in the same cycle; mid-RUN reset discards the count.
REQ-030 First START_STOP is honoured on the first edge after RST deasserts.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-031 Reset, then START_STOP pulse at edge 0 -> RUNNING=1 after edge 0; COUNT_BCD=16'h0001 after edge 4, 16'h0002 after edge 8.
REQ-032 Run 100 ticks from zero -> COUNT_BCD=16'h0100; 600 ticks -> 16'h1000 (sec_tens wraps at 6).
REQ-033 Preload by running to 16'h9599, one more tick -> 16'h0000, RUNNING stays 1.
REQ-034 Run to 16'h0003, START_STOP (pause), idle 20 cycles -> count holds 16'h0003; CLEAR -> IDLE, 16'h0000; CLEAR while RUN -> no effect.
REQ-035 START_STOP+CLEAR together in PAUSE -> IDLE, count 0, RUNNING 0; together in RUN -> PAUSE, count held.
REQ-036 Count 16'h1234 paused -> DIGIT_SEL cycles 0001,0010,0100,1000 every 2 cycles with DIGIT_DATA 4,3,2,1; RST mid-RUN -> all REQ-027/028 values next cycle.
